// File: rtl/img_mem_arbiter_if.sv
// Engine request/grant bus and pixel-memory bus for img_mem_arbiter.
// The slave modport is the arbiter's view; master is the engine/memory side.
interface img_mem_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 24
);
    logic              eng_req;
    logic              eng_we;
    logic [ADDR_W-1:0] eng_addr;
    logic [DATA_W-1:0] eng_wdata;
    logic              eng_gnt;
    logic [DATA_W-1:0] eng_rdata;
    logic              eng_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output eng_req, eng_we, eng_addr, eng_wdata, mem_rdata,
        input  eng_gnt, eng_rdata, eng_rvalid, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  eng_req, eng_we, eng_addr, eng_wdata, mem_rdata,
        output eng_gnt, eng_rdata, eng_rvalid, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/img_mem_arbiter.sv
// Pixel RAM arbiter: display scan-out has fixed priority, engine uses idle slots.
// Define IMG_ARB_HALFFOLD_EN to repeat the top half-frame in the bottom half of the display.
module img_mem_arbiter #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 24,
    parameter int FRAME_PIX = 480000
) (
    input  logic              VGA_CTRL_CLK,
    input  logic              DLY_RST_2,
    input  logic [10:0]       VGA_X,
    input  logic [10:0]       VGA_Y,
    input  logic              VGA_Read,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              frame_done,
    img_mem_arbiter_if.slave  bus
);
    typedef enum logic [0:0] {S_WAIT_SOF, S_RUN} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_ENG} tag_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_PIX - 1);
    localparam logic [ADDR_W-1:0] HALF_IDX = ADDR_W'(FRAME_PIX / 2);

    state_t            state_reg;
    tag_t              tag_reg;
    logic [ADDR_W-1:0] disp_cnt_reg, disp_cnt_next;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              mem_we_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic [DATA_W-1:0] disp_data_reg, eng_rdata_reg;
    logic              disp_valid_reg, eng_rvalid_reg, frame_done_reg;

    logic              sof, run, disp_go, eng_go, wrap;
    logic [ADDR_W-1:0] issue_idx, disp_addr;

    assign sof     = (VGA_X == 11'd0) && (VGA_Y == 11'd0);
    assign run     = (state_reg == S_RUN);
    assign disp_go = run && VGA_Read;
    assign eng_go  = bus.eng_req && !disp_go;
    assign wrap    = disp_go && !sof && (disp_cnt_reg == LAST_IDX);

    // SOF restarts the scan even if the counter has not reached the end
    assign issue_idx = sof ? '0 : disp_cnt_reg;

`ifdef IMG_ARB_HALFFOLD_EN
    assign disp_addr = (issue_idx < HALF_IDX) ? issue_idx : issue_idx - HALF_IDX;
`else
    assign disp_addr = issue_idx;
`endif

    always_comb begin
        disp_cnt_next = disp_cnt_reg;
        if (run) begin
            if (sof)
                disp_cnt_next = VGA_Read ? ADDR_W'(1) : '0;
            else if (VGA_Read)
                disp_cnt_next = (disp_cnt_reg == LAST_IDX) ? '0 : disp_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge VGA_CTRL_CLK or negedge DLY_RST_2) begin
        if (!DLY_RST_2) begin
            state_reg      <= S_WAIT_SOF;
            tag_reg        <= TAG_NONE;
            disp_cnt_reg   <= '0;
            mem_addr_reg   <= '0;
            mem_we_reg     <= 1'b0;
            mem_wdata_reg  <= '0;
            disp_data_reg  <= '0;
            disp_valid_reg <= 1'b0;
            eng_rdata_reg  <= '0;
            eng_rvalid_reg <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            if (state_reg == S_WAIT_SOF && sof)
                state_reg <= S_RUN;
            disp_cnt_reg   <= disp_cnt_next;
            frame_done_reg <= wrap;

            // Slot issue: mem_addr holds when the slot is unused
            mem_we_reg <= 1'b0;
            tag_reg    <= TAG_NONE;
            if (disp_go) begin
                mem_addr_reg <= disp_addr;
                tag_reg      <= TAG_DISP;
            end else if (eng_go) begin
                mem_addr_reg <= bus.eng_addr;
                mem_we_reg   <= bus.eng_we;
                if (bus.eng_we)
                    mem_wdata_reg <= bus.eng_wdata;
                tag_reg <= bus.eng_we ? TAG_NONE : TAG_ENG;
            end

            // Memory output arrives one cycle after issue; route it by tag
            disp_valid_reg <= (tag_reg == TAG_DISP);
            eng_rvalid_reg <= (tag_reg == TAG_ENG);
            if (tag_reg == TAG_DISP)
                disp_data_reg <= bus.mem_rdata;
            if (tag_reg == TAG_ENG)
                eng_rdata_reg <= bus.mem_rdata;
        end
    end

    assign disp_data      = disp_data_reg;
    assign disp_valid     = disp_valid_reg;
    assign frame_done     = frame_done_reg;
    assign bus.eng_gnt    = eng_go;
    assign bus.eng_rdata  = eng_rdata_reg;
    assign bus.eng_rvalid = eng_rvalid_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_we     = mem_we_reg;
    assign bus.mem_wdata  = mem_wdata_reg;
endmodule

// File: tb/tb_img_mem_arbiter.sv
// Directed bench for img_mem_arbiter with a 32-pixel frame and a small
// negedge-clocked RAM model preloaded with 0x0A0000 + index.
module tb_img_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] vx, vy;
    logic        vread;
    logic [23:0] disp_data;
    logic        disp_valid, frame_done;
    int          checks = 0;
    int          errors = 0;

    logic [23:0] ram [0:63];
    logic [23:0] q;

    img_mem_arbiter_if #(.ADDR_W(19), .DATA_W(24)) bus();

    img_mem_arbiter #(.ADDR_W(19), .DATA_W(24), .FRAME_PIX(32)) dut (
        .VGA_CTRL_CLK (clk),
        .DLY_RST_2    (rst_n),
        .VGA_X        (vx),
        .VGA_Y        (vy),
        .VGA_Read     (vread),
        .disp_data    (disp_data),
        .disp_valid   (disp_valid),
        .frame_done   (frame_done),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] init_word(int i);
        return 24'h0A0000 + 24'(i);
    endfunction

    // Expected display memory address for scan index j of a 32-pixel frame
    function automatic logic [18:0] exp_addr(int j);
`ifdef IMG_ARB_HALFFOLD_EN
        return (j >= 16) ? 19'(j - 16) : 19'(j);
`else
        return 19'(j);
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
            q <= '0;
        end else begin
            if (bus.mem_we) ram[bus.mem_addr[5:0]] <= bus.mem_wdata;
            q <= ram[bus.mem_addr[5:0]];
        end
    end
    assign bus.mem_rdata = q;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vread = 1'b0; vx = 11'd5; vy = 11'd3;
        bus.eng_req = 1'b0; bus.eng_we = 1'b0; bus.eng_addr = '0; bus.eng_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (disp_data !== 24'h0) begin errors++; $display("FAIL rst_disp_data got %h want 0", disp_data); end
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL rst_disp_valid got %b want 0", disp_valid); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %b want 0", frame_done); end
        checks++; if (bus.eng_rdata !== 24'h0) begin errors++; $display("FAIL rst_eng_rdata got %h want 0", bus.eng_rdata); end
        checks++; if (bus.eng_rvalid !== 1'b0) begin errors++; $display("FAIL rst_eng_rvalid got %b want 0", bus.eng_rvalid); end
        checks++; if (bus.mem_addr !== 19'h0) begin errors++; $display("FAIL rst_mem_addr got %h want 0", bus.mem_addr); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b want 0", bus.mem_we); end
        checks++; if (bus.mem_wdata !== 24'h0) begin errors++; $display("FAIL rst_mem_wdata got %h want 0", bus.mem_wdata); end
        rst_n = 1'b1;
        cyc();
        $display("reset: outputs checked");
    endtask

    task automatic test_wait_sof();
        vx = 11'd5; vy = 11'd0; vread = 1'b1;
        repeat (10) begin
            cyc();
            checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL wait_disp_valid got %b want 0", disp_valid); end
            checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL wait_mem_we got %b want 0", bus.mem_we); end
        end
        bus.eng_req = 1'b1; bus.eng_we = 1'b0; bus.eng_addr = 19'h00010;
        #1;
        checks++; if (bus.eng_gnt !== 1'b1) begin errors++; $display("FAIL wait_eng_gnt got %b want 1", bus.eng_gnt); end
        cyc();
        bus.eng_req = 1'b0;
        checks++; if (bus.mem_addr !== 19'h00010) begin errors++; $display("FAIL wait_mem_addr got %h want 00010", bus.mem_addr); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL wait_rd_we got %b want 0", bus.mem_we); end
        cyc();
        checks++; if (bus.eng_rvalid !== 1'b1) begin errors++; $display("FAIL wait_eng_rvalid got %b want 1", bus.eng_rvalid); end
        checks++; if (bus.eng_rdata !== 24'h0A0010) begin errors++; $display("FAIL wait_eng_rdata got %h want 0a0010", bus.eng_rdata); end
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL wait_no_disp got %b want 0", disp_valid); end
        $display("engine read addr 00010 data %h", bus.eng_rdata);
        cyc();
        checks++; if (bus.eng_rvalid !== 1'b0) begin errors++; $display("FAIL wait_rvalid_drop got %b want 0", bus.eng_rvalid); end
    endtask

    task automatic test_display();
        // first SOF only arms the scan; that cycle is not a display slot
        vx = 11'd0; vy = 11'd0; vread = 1'b0;
        cyc();
        vx = 11'd1;
        cyc(); cyc();
        for (int k = 0; k < 8; k++) begin
            vread = (k < 5); vx = 11'(k); vy = 11'd0;
            if (k >= 1 && k <= 5) begin
                checks++; if (bus.mem_addr !== 19'(k - 1)) begin errors++; $display("FAIL disp_mem_addr[%0d] got %h want %h", k - 1, bus.mem_addr, 19'(k - 1)); end
            end
            if (k >= 2 && k <= 6) begin
                checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL disp_valid[%0d] got %b want 1", k - 2, disp_valid); end
                checks++; if (disp_data !== init_word(k - 2)) begin errors++; $display("FAIL disp_data[%0d] got %h want %h", k - 2, disp_data, init_word(k - 2)); end
                $display("display read idx %0d data %h", k - 2, disp_data);
            end
            if (k == 7) begin
                checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL disp_valid_end got %b want 0", disp_valid); end
            end
            cyc();
        end
    endtask

    task automatic test_contention();
        vx = 11'd20; vy = 11'd1; vread = 1'b1;
        bus.eng_req = 1'b1; bus.eng_we = 1'b1; bus.eng_addr = 19'd5; bus.eng_wdata = 24'hABCDEF;
        #1;
        checks++; if (bus.eng_gnt !== 1'b0) begin errors++; $display("FAIL cont_gnt_blocked got %b want 0", bus.eng_gnt); end
        cyc();
        checks++; if (bus.mem_addr !== 19'd5) begin errors++; $display("FAIL cont_disp_addr got %h want 5", bus.mem_addr); end
        vread = 1'b0;
        #1;
        checks++; if (bus.eng_gnt !== 1'b1) begin errors++; $display("FAIL cont_gnt_idle got %b want 1", bus.eng_gnt); end
        cyc();
        bus.eng_req = 1'b0; bus.eng_we = 1'b0;
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL cont_mem_we got %b want 1", bus.mem_we); end
        checks++; if (bus.mem_addr !== 19'd5) begin errors++; $display("FAIL cont_wr_addr got %h want 5", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 24'hABCDEF) begin errors++; $display("FAIL cont_wdata got %h want abcdef", bus.mem_wdata); end
        checks++; if (disp_data !== 24'h0A0005) begin errors++; $display("FAIL cont_old_data got %h want 0a0005", disp_data); end
        $display("engine write addr 5 data abcdef");
        cyc();
        checks++; if (bus.eng_rvalid !== 1'b0) begin errors++; $display("FAIL cont_wr_no_rvalid got %b want 0", bus.eng_rvalid); end
        // rescan from SOF and read index 5 back
        for (int k = 0; k < 8; k++) begin
            vread = (k < 6); vx = 11'(k); vy = 11'd0;
            if (k == 7) begin
                checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL cont_rb_valid got %b want 1", disp_valid); end
                checks++; if (disp_data !== 24'hABCDEF) begin errors++; $display("FAIL cont_rb_data got %h want abcdef", disp_data); end
                $display("display read idx 5 data %h", disp_data);
            end
            cyc();
        end
        // write at T, display reads the same address at T+1
        vx = 11'd30; vy = 11'd1; vread = 1'b0;
        bus.eng_req = 1'b1; bus.eng_we = 1'b1; bus.eng_addr = 19'd6; bus.eng_wdata = 24'h123456;
        #1;
        checks++; if (bus.eng_gnt !== 1'b1) begin errors++; $display("FAIL fwd_gnt got %b want 1", bus.eng_gnt); end
        cyc();
        bus.eng_req = 1'b0; bus.eng_we = 1'b0; vread = 1'b1;
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL fwd_mem_we got %b want 1", bus.mem_we); end
        cyc();
        vread = 1'b0;
        checks++; if (bus.mem_addr !== 19'd6) begin errors++; $display("FAIL fwd_disp_addr got %h want 6", bus.mem_addr); end
        cyc();
        checks++; if (disp_data !== 24'h123456) begin errors++; $display("FAIL fwd_data got %h want 123456", disp_data); end
        $display("display read idx 6 data %h", disp_data);
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 35; k++) begin
            vread = (k <= 32);
            vx = (k == 0) ? 11'd0 : 11'(k);
            vy = (k == 0) ? 11'd0 : 11'd1;
            if (k >= 1 && k <= 33) begin
                checks++; if (bus.mem_addr !== exp_addr((k - 1) % 32)) begin errors++; $display("FAIL wrap_addr[%0d] got %h want %h", k - 1, bus.mem_addr, exp_addr((k - 1) % 32)); end
            end
            checks++; if (frame_done !== (k == 32)) begin errors++; $display("FAIL wrap_frame_done[%0d] got %b want %b", k, frame_done, (k == 32)); end
            cyc();
        end
        $display("frame of 32 reads wrapped");
    endtask

    task automatic test_reset_midflight();
        vx = 11'd0; vy = 11'd0; vread = 1'b1; bus.eng_req = 1'b0;
        cyc();
        vx = 11'd1; vread = 1'b0;
        bus.eng_req = 1'b1; bus.eng_we = 1'b0; bus.eng_addr = 19'd3;
        cyc();
        bus.eng_req = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_addr !== 19'd0) begin errors++; $display("FAIL mid_rst_addr got %h want 0", bus.mem_addr); end
        repeat (2) cyc();
        rst_n = 1'b1; vx = 11'd3; vy = 11'd1; vread = 1'b1;
        repeat (6) begin
            cyc();
            checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL mid_disp_valid got %b want 0", disp_valid); end
            checks++; if (bus.eng_rvalid !== 1'b0) begin errors++; $display("FAIL mid_eng_rvalid got %b want 0", bus.eng_rvalid); end
        end
        bus.eng_req = 1'b1; bus.eng_we = 1'b0; bus.eng_addr = 19'd2;
        #1;
        checks++; if (bus.eng_gnt !== 1'b1) begin errors++; $display("FAIL mid_wait_gnt got %b want 1", bus.eng_gnt); end
        cyc();
        bus.eng_req = 1'b0;
        cyc();
        checks++; if (bus.eng_rdata !== 24'h0A0002) begin errors++; $display("FAIL mid_eng_rdata got %h want 0a0002", bus.eng_rdata); end
        $display("reset mid-flight: engine read addr 2 data %h", bus.eng_rdata);
    endtask

    initial begin
        test_reset();
        test_wait_sof();
        test_display();
        test_contention();
        test_wrap();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
